tamagotchi_btn_ctrl: RTL and testbench
======================================

TAMAGOTCHI_BTN_CTRL -- requirements
Module: tamagotchi_btn_ctrl

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles required to accept a button level change (minimum 1).
REQ-002 The module SHALL have parameter TICK_CYCLES, default 10, giving the clock cycles per hold-count increment.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 raw_salud, raw_energia, raw_hambre, raw_diversion  input  1 each  raw active-high care buttons, asynchronous to clk, may bounce.
REQ-006 raw_reset, raw_test  input  1 each  raw active-high mode buttons, asynchronous to clk, may bounce.
REQ-007 btn_salud, btn_energia, btn_hambre, btn_diversion  output  1 each  single-cycle press pulses for tamagotchi_fsm.
REQ-008 btn_reset, btn_test  output  1 each  debounced held level.
REQ-009 count_reset, count_test  output  3 each  completed hold ticks of the matching mode button.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL have a state machine with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a debounce counter.
REQ-012 IDLE transitions: synced=1 -> PRESS_WAIT with counter cleared.
REQ-013 PRESS_WAIT transitions: synced=0 -> IDLE; otherwise count up, and on reaching DEBOUNCE_CYCLES consecutive 1s -> HELD.
REQ-014 HELD transitions: synced=0 -> RELEASE_WAIT with counter cleared.
REQ-015 RELEASE_WAIT transitions: synced=1 -> HELD; otherwise count up, and on reaching DEBOUNCE_CYCLES consecutive 0s -> IDLE.
REQ-016 Latency: a raw rise held stably before edge 1 SHALL enter HELD at edge 2+DEBOUNCE_CYCLES (edge 6 at default).
REQ-017 Care-button pulse SHALL be high for exactly the one cycle following the edge at which that button enters HELD.
REQ-018 No pulse SHALL be generated on release, on the RELEASE_WAIT->HELD transition, or while a button remains held.
REQ-019 At most one care pulse SHALL be high per cycle.
REQ-020 Simultaneous HELD entry SHALL use priority salud > energia > hambre > diversion.
REQ-021 Care buttons losing priority SHALL be dropped, not queued, and SHALL produce no later pulse for that press.
REQ-022 btn_reset/btn_test SHALL be 1 in HELD and RELEASE_WAIT and 0 in IDLE and PRESS_WAIT.
REQ-023 Each mode button SHALL have a tick counter, 0..TICK_CYCLES-1, counting while its level output is 1 and wrapping at TICK_CYCLES-1.
REQ-024 count_reset/count_test SHALL increment on each tick wrap, saturating at 7 with no wrap to 0.
REQ-025 On the edge a mode button enters IDLE, its count and tick counter SHALL clear to 0; a RELEASE_WAIT bounce back to HELD SHALL preserve both.
REQ-026 Mode and care buttons SHALL be independent; mode buttons SHALL not suppress care pulses.

Reset
REQ-027 rst_n=0 SHALL immediately force all outputs to 0, all states to IDLE, and all counters and synchronizer flops to 0, independent of clk.
REQ-028 After rst_n rises, a raw input already held high SHALL be treated as a new press with full REQ-016 latency.
REQ-029 Reset mid-hold SHALL discard any accumulated count.

Verification
REQ-030 raw_salud high 20 cycles -> btn_salud exactly one 1-cycle pulse after edge 6; none on release; other outputs stay 0.
REQ-031 raw_energia high 3 cycles then low -> no btn_energia pulse; state returns to IDLE.
REQ-032 raw toggling every cycle for 10 cycles, then stable high -> exactly one pulse.
REQ-033 raw_reset held 100 cycles -> btn_reset=1 from edge 6; count_reset=1 ten cycles later, +1 every 10 cycles, 7 thereafter; on release count_reset=0 on the edge btn_reset falls.
REQ-034 raw_salud and raw_hambre rise on the same cycle -> only btn_salud pulses; btn_hambre never pulses for that press.
REQ-035 rst_n low while raw_test held with count_test=3 -> outputs 0 at once; after release, btn_test=1 again 6 edges later and count_test restarts from 0.

Source files
------------

// File: rtl/tamagotchi_btn_ctrl.sv
// rtl/tamagotchi_btn_ctrl.sv - debounced care-button pulses and mode-button hold levels/counts
module tamagotchi_btn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_CYCLES     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_salud,
    input  logic       raw_energia,
    input  logic       raw_hambre,
    input  logic       raw_diversion,
    input  logic       raw_reset,
    input  logic       raw_test,
    output logic       btn_salud,
    output logic       btn_energia,
    output logic       btn_hambre,
    output logic       btn_diversion,
    output logic       btn_reset,
    output logic       btn_test,
    output logic [2:0] count_reset,
    output logic [2:0] count_test
);

    localparam int NB = 6;
    localparam int DB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    // The sample that leaves IDLE/HELD is the first of the run, so the counter only needs DB-2.
    localparam int CW = (DB > 2) ? $clog2(DB - 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((DB >= 2) ? DB - 2 : 0);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    logic [NB-1:0] raw_vec;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [3:0]    care_enter;
    logic [3:0]    care_grant;
    logic [3:0]    pulse_q;
    logic [1:0]    mode_level;
    logic [1:0]    mode_leave;
    logic [5:0]    mode_cnt;

    assign raw_vec = {raw_test, raw_reset, raw_diversion, raw_hambre, raw_energia, raw_salud};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_btn
        btn_state_t    state_q;
        btn_state_t    state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    if (sync2[i]) begin
                        cnt_d   = '0;
                        state_d = (DB == 1) ? HELD : PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2[i]) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync2[i]) begin
                        cnt_d   = '0;
                        state_d = (DB == 1) ? IDLE : RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2[i]) begin
                        state_d = HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (i < 4) begin : g_care
            // Only a fresh press counts; a bounce back from RELEASE_WAIT is not a new entry.
            assign care_enter[i] = (state_d == HELD) && (state_q != HELD) && (state_q != RELEASE_WAIT);
        end else begin : g_mode
            assign mode_level[i-4] = (state_q == HELD) || (state_q == RELEASE_WAIT);
            assign mode_leave[i-4] = (state_d == IDLE) && (state_q != IDLE);
        end
    end

    always_comb begin
        care_grant = 4'b0000;
        if (care_enter[0]) begin
            care_grant = 4'b0001;
        end else if (care_enter[1]) begin
            care_grant = 4'b0010;
        end else if (care_enter[2]) begin
            care_grant = 4'b0100;
        end else if (care_enter[3]) begin
            care_grant = 4'b1000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= care_grant;
        end
    end

    for (genvar j = 0; j < 2; j++) begin : g_hold
        logic [TW-1:0] tick_q;
        logic [2:0]    hold_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tick_q <= '0;
                hold_q <= '0;
            end else if (mode_leave[j]) begin
                tick_q <= '0;
                hold_q <= '0;
            end else if (mode_level[j]) begin
                if (tick_q == TICK_LAST) begin
                    tick_q <= '0;
                    if (hold_q != 3'd7) begin
                        hold_q <= hold_q + 3'd1;
                    end
                end else begin
                    tick_q <= tick_q + 1'b1;
                end
            end
        end

        assign mode_cnt[j*3 +: 3] = hold_q;
    end

    assign btn_salud     = pulse_q[0];
    assign btn_energia   = pulse_q[1];
    assign btn_hambre    = pulse_q[2];
    assign btn_diversion = pulse_q[3];
    assign btn_reset     = mode_level[0];
    assign btn_test      = mode_level[1];
    assign count_reset   = mode_cnt[2:0];
    assign count_test    = mode_cnt[5:3];

endmodule

// File: tb/tb_tamagotchi_btn_ctrl.sv
// tb/tb_tamagotchi_btn_ctrl.sv - randomized bench for tamagotchi_btn_ctrl against a run-length reference model
module tb_tamagotchi_btn_ctrl;

    localparam int DB = 4;
    localparam int TK = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       raw_salud, raw_energia, raw_hambre, raw_diversion, raw_reset, raw_test;
    logic       btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test;
    logic [2:0] count_reset, count_test;

    always #5 clk = ~clk;

    tamagotchi_btn_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_CYCLES    (TK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_salud    (raw_salud),
        .raw_energia  (raw_energia),
        .raw_hambre   (raw_hambre),
        .raw_diversion(raw_diversion),
        .raw_reset    (raw_reset),
        .raw_test     (raw_test),
        .btn_salud    (btn_salud),
        .btn_energia  (btn_energia),
        .btn_hambre   (btn_hambre),
        .btn_diversion(btn_diversion),
        .btn_reset    (btn_reset),
        .btn_test     (btn_test),
        .count_reset  (count_reset),
        .count_test   (count_test)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: bit order salud, energia, hambre, diversion, reset, test.
    bit         m_s1      [6];
    bit         m_s2      [6];
    bit         m_lvl     [6];
    bit         m_run_val [6];
    int         m_run_len [6];
    int         m_hold    [2];
    logic [3:0] m_pulse;

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run_val[i] = 0; m_run_len[i] = 0;
        end
        m_hold[0] = 0;
        m_hold[1] = 0;
        m_pulse   = '0;
    endfunction

    function automatic void model_edge(input logic [5:0] raw);
        bit rise [6];
        bit prev;
        bit seen;
        for (int i = 0; i < 6; i++) begin
            seen = m_s2[i];
            if (seen == m_run_val[i]) m_run_len[i]++;
            else begin
                m_run_val[i] = seen;
                m_run_len[i] = 1;
            end
            prev = m_lvl[i];
            if (!m_lvl[i] && seen && m_run_len[i] >= DB) m_lvl[i] = 1;
            else if (m_lvl[i] && !seen && m_run_len[i] >= DB) m_lvl[i] = 0;
            rise[i] = !prev && m_lvl[i];
            if (i >= 4) begin
                if (prev && !m_lvl[i]) m_hold[i-4] = 0;
                else if (prev) m_hold[i-4]++;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        m_pulse = '0;
        for (int i = 0; i < 4; i++) begin
            if (rise[i] && m_pulse == 4'b0000) m_pulse[i] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] exp_count(input int n);
        return (n / TK > 7) ? 32'd7 : 32'(n / TK);
    endfunction

    task automatic drive(input logic [5:0] r);
        raw_salud     = r[0];
        raw_energia   = r[1];
        raw_hambre    = r[2];
        raw_diversion = r[3];
        raw_reset     = r[4];
        raw_test      = r[5];
    endtask

    task automatic check_outputs();
        check_eq("care_pulse", {28'd0, btn_diversion, btn_hambre, btn_energia, btn_salud}, {28'd0, m_pulse});
        check_eq("btn_reset", {31'd0, btn_reset}, {31'd0, m_lvl[4]});
        check_eq("btn_test", {31'd0, btn_test}, {31'd0, m_lvl[5]});
        check_eq("count_reset", {29'd0, count_reset}, exp_count(m_hold[0]));
        check_eq("count_test", {29'd0, count_test}, exp_count(m_hold[1]));
    endtask

    task automatic check_zero();
        check_eq("rst_pulse", {28'd0, btn_diversion, btn_hambre, btn_energia, btn_salud}, 32'd0);
        check_eq("rst_level", {30'd0, btn_test, btn_reset}, 32'd0);
        check_eq("rst_count", {26'd0, count_test, count_reset}, 32'd0);
    endtask

    task automatic step(input logic [5:0] r);
        @(negedge clk);
        drive(r);
        @(posedge clk);
        model_edge(r);
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero();
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    int         n_sal, n_hamb, n_ener, first_hi;
    logic [5:0] cur;

    initial begin
        rst_n = 1'b0;
        drive(6'b0);
        model_reset();
        #3 check_zero();
        @(posedge clk);
        #2 rst_n = 1'b1;

        repeat (5) step(6'b000000);

        n_sal = 0;
        for (int k = 0; k < 20; k++) begin step(6'b000001); n_sal += int'(btn_salud); end
        for (int k = 0; k < 10; k++) begin step(6'b000000); n_sal += int'(btn_salud); end
        check_eq("salud_single_pulse", 32'(n_sal), 32'd1);

        n_ener = 0;
        for (int k = 0; k < 3; k++) begin step(6'b000010); n_ener += int'(btn_energia); end
        for (int k = 0; k < 10; k++) begin step(6'b000000); n_ener += int'(btn_energia); end
        check_eq("energia_short_press", 32'(n_ener), 32'd0);

        n_sal = 0;
        for (int k = 0; k < 10; k++) begin step({5'd0, k[0]}); n_sal += int'(btn_salud); end
        for (int k = 0; k < 15; k++) begin step(6'b000001); n_sal += int'(btn_salud); end
        for (int k = 0; k < 10; k++) begin step(6'b000000); n_sal += int'(btn_salud); end
        check_eq("salud_bounce_pulse", 32'(n_sal), 32'd1);

        for (int k = 0; k < 100; k++) step(6'b010000);
        check_eq("count_reset_sat", {29'd0, count_reset}, 32'd7);
        for (int k = 0; k < 10; k++) step(6'b000000);

        n_sal = 0;
        n_hamb = 0;
        for (int k = 0; k < 15; k++) begin
            step(6'b000101);
            n_sal += int'(btn_salud);
            n_hamb += int'(btn_hambre);
        end
        for (int k = 0; k < 10; k++) step(6'b000000);
        check_eq("prio_salud", 32'(n_sal), 32'd1);
        check_eq("prio_hambre_dropped", 32'(n_hamb), 32'd0);

        for (int k = 0; k < 40; k++) step(6'b100000);
        check_eq("count_test_pre", {29'd0, count_test}, 32'd3);
        async_reset();
        first_hi = -1;
        for (int k = 1; k <= 20; k++) begin
            step(6'b100000);
            if (first_hi < 0 && btn_test) first_hi = k;
        end
        check_eq("test_relatch_edge", 32'(first_hi), 32'd6);
        for (int k = 0; k < 10; k++) step(6'b000000);

        cur = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
            for (int b = 4; b < 6; b++) if ($urandom_range(0, 39) == 0) cur[b] = ~cur[b];
            if (k == 1500) async_reset();
            step(cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
